md_unit: RTL

- Multiply/divide responder for the P7 pipeline. It executes the Start/XAluOp commands that the main controller issues from the E stage.
- Holds the architectural HI/LO registers and models multi-cycle latency with a busy counter. The hazard unit stalls D-stage md instructions on Start|Busy.
- Sits beside the ALU in the E stage. Operands come from forwarded rs/rt values.

---
 rtl/md_unit_pkg.sv | 38 +++
 rtl/md_core.sv | 57 +++++
 rtl/md_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared command encodings, latency defaults and state encoding for the md_unit
// multiply/divide responder and the main controller that drives it.
package md_unit_pkg;

    typedef enum logic [1:0] {
        StartNone = 2'b00,
        StartMd   = 2'b01,
        StartMove = 2'b10,
        StartRsvd = 2'b11
    } start_e;

    typedef enum logic [2:0] {
        OpMult  = 3'b000,
        OpMultu = 3'b001,
        OpDiv   = 3'b010,
        OpDivu  = 3'b011,
        OpMthi  = 3'b100,
        OpMtlo  = 3'b101
    } xalu_op_e;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    localparam int unsigned MultLatDefault = 5;
    localparam int unsigned DivLatDefault  = 10;

    // Low two XAluOp bits of a mult/div op: bit 1 selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_core.sv
// Combinational 32x32 signed/unsigned multiply and divide/remainder.
// Divide goes through magnitudes so no operand pair can reach an undefined quotient.
module md_core
    import md_unit_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_zero_o
);

    logic        is_signed;
    logic        is_div;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        is_signed = op_is_signed(op_i);
        is_div    = op_is_div(op_i);

        a_ext = is_signed ? {{32{a_i[31]}}, a_i} : {32'd0, a_i};
        b_ext = is_signed ? {{32{b_i[31]}}, b_i} : {32'd0, b_i};
        prod  = a_ext * b_ext;

        a_neg = is_signed & a_i[31];
        b_neg = is_signed & b_i[31];
        a_mag = a_neg ? (~a_i + 32'd1) : a_i;
        b_mag = b_neg ? (~b_i + 32'd1) : b_i;

        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end else begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end

        // Quotient truncates toward zero; remainder follows the dividend's sign.
        quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem  = a_neg ? (~r_mag + 32'd1) : r_mag;

        div_zero_o = is_div & (b_i == 32'd0);
        {hi_o, lo_o} = is_div ? {rem, quot} : prod;
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide responder: owns HI/LO and holds Busy for the op latency.
// The result is computed at Start and parked until the busy counter expires.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned MULT_LAT = MultLatDefault,
    parameter int unsigned DIV_LAT  = DivLatDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Start,
    input  logic [2:0]  XAluOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Block,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    md_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;

    logic [31:0]     core_hi;
    logic [31:0]     core_lo;
    logic            core_div_zero;
    logic            md_start;
    logic            move_start;

    md_core u_md_core (
        .op_i       (XAluOp[1:0]),
        .a_i        (A),
        .b_i        (B),
        .hi_o       (core_hi),
        .lo_o       (core_lo),
        .div_zero_o (core_div_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    always_comb begin
        md_start   = !Block && (Start == StartMd) && (XAluOp[2] == 1'b0);
        move_start = !Block && (Start == StartMove);

        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;

        case (state_q)
            StIdle: begin
                if (md_start) begin
                    // Divide by zero parks the current HI/LO so completion leaves them intact.
                    pend_hi_d = core_div_zero ? hi_q : core_hi;
                    pend_lo_d = core_div_zero ? lo_q : core_lo;
                    cnt_d     = op_is_div(XAluOp[1:0]) ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
                    state_d   = StRun;
                end else if (move_start) begin
                    if (XAluOp == OpMthi) begin
                        hi_d = A;
                    end else if (XAluOp == OpMtlo) begin
                        lo_d = A;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        Busy = (state_q == StRun);
        HI   = hi_q;
        LO   = lo_q;
    end

endmodule
